ctl_unit: RTL and testbench

CTL_UNIT -- requirements
Module: ctl_unit

---
 rtl/ctl_unit.sv | 205 ++++++++++++++++++++
 tb/tb_ctl_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctl_unit.sv
// ctl_unit: multi-cycle control unit for a small accumulator machine with
// inbox/outbox queues. Registered state and instruction register; every
// strobe is decoded from the current state, the held IR and the status inputs.
// Build option: INDIRECT_ADDR_EN enables the INDIRECT state, which does a
// second address load (AR <= mem[AR]) for operand opcodes 2-7 with IR[3]=1.
// Without it, IR[3] is ignored and ar_ind_ld stays 0.
module ctl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       flag,
    input  logic       inbox_empty,
    input  logic       outbox_full,
    output logic [2:0] aluCtl,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       ar_ld,
    output logic       ar_ind_ld,
    output logic       mem_wr,
    output logic       r_ld,
    output logic       inbox_rd,
    output logic       outbox_wr,
    output logic [1:0] r_sel,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        FETCH_ARG = 3'd2,
        EXEC      = 3'd3,
`ifdef INDIRECT_ADDR_EN
        INDIRECT  = 3'd5,
`endif
        HALT      = 3'd4
    } state_t;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPUP   = 4'h6;
    localparam logic [3:0] OP_BUMPDN   = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    state_t     state;
    state_t     next_state;
    logic [7:0] ir;
    logic [3:0] opcode;

    assign opcode = ir[7:4];

    // Low IR bits carry the operand hint only; they never steer control here.
`ifdef INDIRECT_ADDR_EN
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[2:0];
`else
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[3:0];
`endif

    // State register and instruction register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ir    <= 8'h00;
        end else begin
            state <= next_state;
            if (state == FETCH) begin
                ir <= instr;
            end
        end
    end

    // Next-state and strobe decode; everything forced low while rst is high.
    always_comb begin
        next_state = state;
        aluCtl     = 3'b000;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        ar_ld      = 1'b0;
        ar_ind_ld  = 1'b0;
        mem_wr     = 1'b0;
        r_ld       = 1'b0;
        inbox_rd   = 1'b0;
        outbox_wr  = 1'b0;
        r_sel      = 2'b00;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    ir_ld      = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    if (opcode == OP_INBOX || opcode == OP_OUTBOX) begin
                        next_state = EXEC;
                    end else if (opcode <= OP_JUMPN) begin
                        next_state = FETCH_ARG;
                    end else begin
                        next_state = HALT;
                    end
                end
                FETCH_ARG: begin
                    ar_ld      = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = EXEC;
`ifdef INDIRECT_ADDR_EN
                    if (ir[3] && opcode >= OP_COPYFROM && opcode <= OP_BUMPDN) begin
                        next_state = INDIRECT;
                    end
`endif
                end
`ifdef INDIRECT_ADDR_EN
                INDIRECT: begin
                    ar_ind_ld  = 1'b1;
                    next_state = EXEC;
                end
`endif
                EXEC: begin
                    next_state = FETCH;
                    case (opcode)
                        OP_INBOX: begin
                            if (inbox_empty) begin
                                next_state = EXEC;
                            end else begin
                                r_ld     = 1'b1;
                                r_sel    = 2'b00;
                                inbox_rd = 1'b1;
                            end
                        end
                        OP_OUTBOX: begin
                            if (outbox_full) begin
                                next_state = EXEC;
                            end else begin
                                outbox_wr = 1'b1;
                            end
                        end
                        OP_COPYFROM: begin
                            r_ld  = 1'b1;
                            r_sel = 2'b01;
                        end
                        OP_COPYTO: begin
                            mem_wr = 1'b1;
                        end
                        OP_ADD: begin
                            r_ld   = 1'b1;
                            r_sel  = 2'b10;
                            aluCtl = 3'b000;
                        end
                        OP_SUB: begin
                            r_ld   = 1'b1;
                            r_sel  = 2'b10;
                            aluCtl = 3'b001;
                        end
                        OP_BUMPUP: begin
                            r_ld   = 1'b1;
                            r_sel  = 2'b10;
                            mem_wr = 1'b1;
                            aluCtl = 3'b010;
                        end
                        OP_BUMPDN: begin
                            r_ld   = 1'b1;
                            r_sel  = 2'b10;
                            mem_wr = 1'b1;
                            aluCtl = 3'b011;
                        end
                        OP_JUMP: begin
                            pc_ld = 1'b1;
                        end
                        OP_JUMPZ: begin
                            aluCtl = 3'b000;
                            pc_ld  = flag;
                        end
                        OP_JUMPN: begin
                            aluCtl = 3'b100;
                            pc_ld  = flag;
                        end
                        default: begin
                            next_state = FETCH;
                        end
                    endcase
                end
                HALT: begin
                    halted  = 1'b1;
                    illegal = (opcode != OP_HALT) && (opcode > OP_JUMPN);
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctl_unit.sv
// tb_ctl_unit: table-driven cycle-by-cycle check of ctl_unit outputs, plus
// hand-written reset / halt / illegal sequences. Expectations follow the
// INDIRECT_ADDR_EN setting used to build the design.
module tb_ctl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       flag = 1'b0;
    logic       inbox_empty = 1'b1;
    logic       outbox_full = 1'b0;
    logic [2:0] aluCtl;
    logic       ir_ld, pc_inc, pc_ld, ar_ld, ar_ind_ld, mem_wr, r_ld, inbox_rd, outbox_wr;
    logic [1:0] r_sel;
    logic       halted, illegal;

    ctl_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .flag(flag),
        .inbox_empty(inbox_empty), .outbox_full(outbox_full),
        .aluCtl(aluCtl), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .ar_ld(ar_ld), .ar_ind_ld(ar_ind_ld), .mem_wr(mem_wr), .r_ld(r_ld),
        .inbox_rd(inbox_rd), .outbox_wr(outbox_wr), .r_sel(r_sel),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Bundled view of every output: alu, 9 strobes, r_sel, halted, illegal.
    typedef struct packed {
        logic [2:0] alu;
        logic [8:0] stb;
        logic [1:0] rsel;
        logic       hlt;
        logic       ill;
    } out_t;

    typedef struct {
        string      name;
        logic [7:0] instr;
        logic       ie;
        logic       of;
        logic       fl;
        out_t       exp;
    } vec_t;

    // Strobe order: ir_ld pc_inc pc_ld ar_ld ar_ind_ld mem_wr r_ld inbox_rd outbox_wr
    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_FETCH = 9'b110000000;
    localparam logic [8:0] S_PCLD  = 9'b001000000;
    localparam logic [8:0] S_ARG   = 9'b010100000;
    localparam logic [8:0] S_ARIND = 9'b000010000;
    localparam logic [8:0] S_MEMWR = 9'b000001000;
    localparam logic [8:0] S_RLD   = 9'b000000100;
    localparam logic [8:0] S_INRD  = 9'b000000010;
    localparam logic [8:0] S_OUTWR = 9'b000000001;

    vec_t  vecs[$];
    out_t  expq[$];
    string nameq[$];
    int    passed = 0;
    int    total  = 0;

    function automatic out_t mk(input logic [2:0] alu, input logic [8:0] stb,
                                input logic [1:0] rsel, input logic h, input logic il);
        out_t o;
        o.alu  = alu;
        o.stb  = stb;
        o.rsel = rsel;
        o.hlt  = h;
        o.ill  = il;
        return o;
    endfunction

    function automatic out_t actual();
        out_t o;
        o.alu  = aluCtl;
        o.stb  = {ir_ld, pc_inc, pc_ld, ar_ld, ar_ind_ld, mem_wr, r_ld, inbox_rd, outbox_wr};
        o.rsel = r_sel;
        o.hlt  = halted;
        o.ill  = illegal;
        return o;
    endfunction

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkOutput();
        out_t  e;
        out_t  a;
        string nm;
        @(negedge clk);
        e  = expq.pop_front();
        nm = nameq.pop_front();
        a  = actual();
        total++;
        if (a === e) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h (alu=%b stb=%b rsel=%b h=%b il=%b) expected %h (alu=%b stb=%b rsel=%b h=%b il=%b)",
                     nm, a, a.alu, a.stb, a.rsel, a.hlt, a.ill, e, e.alu, e.stb, e.rsel, e.hlt, e.ill);
        end
    endtask

    // Drive one cycle of inputs just after the edge, queue its expectation, then check.
    task automatic applyStimulus(input string nm, input logic r, input logic [7:0] i,
                                 input logic ie, input logic of, input logic fl, input out_t e);
        @(posedge clk);
        #1;
        rst         = r;
        instr       = i;
        inbox_empty = ie;
        outbox_full = of;
        flag        = fl;
        expq.push_back(e);
        nameq.push_back(nm);
        checkOutput();
    endtask

    task automatic v(input string nm, input logic [7:0] i, input logic ie,
                     input logic of, input logic fl, input out_t e);
        vec_t x;
        x.name = nm; x.instr = i; x.ie = ie; x.of = of; x.fl = fl; x.exp = e;
        vecs.push_back(x);
    endtask

    // Direct-operand instruction: FETCH, DECODE, FETCH_ARG, EXEC.
    task automatic op4(input string nm, input logic [7:0] i, input logic fl, input out_t ex);
        v({nm, "_fetch"},  i,     1'b0, 1'b0, fl, mk(3'b000, S_FETCH, 2'b00, 1'b0, 1'b0));
        v({nm, "_decode"}, i,     1'b0, 1'b0, fl, mk(3'b000, S_NONE,  2'b00, 1'b0, 1'b0));
        v({nm, "_arg"},    8'h05, 1'b0, 1'b0, fl, mk(3'b000, S_ARG,   2'b00, 1'b0, 1'b0));
        v({nm, "_exec"},   8'h00, 1'b0, 1'b0, fl, ex);
    endtask

    initial begin
        out_t none;
        out_t fetch;
        none  = mk(3'b000, S_NONE, 2'b00, 1'b0, 1'b0);
        fetch = mk(3'b000, S_FETCH, 2'b00, 1'b0, 1'b0);

        // INBOX with a 4-cycle stall: ir_ld on cycle 1, inbox_rd on cycle 7.
        v("inbox_fetch",  8'h00, 1'b1, 1'b0, 1'b0, fetch);
        v("inbox_decode", 8'h00, 1'b1, 1'b0, 1'b0, none);
        for (int k = 0; k < 4; k++) v("inbox_stall", 8'h00, 1'b1, 1'b0, 1'b0, none);
        v("inbox_exec",   8'h00, 1'b0, 1'b0, 1'b0, mk(3'b000, S_RLD | S_INRD, 2'b00, 1'b0, 1'b0));
        // OUTBOX with a 2-cycle stall.
        v("outbox_fetch",  8'h10, 1'b0, 1'b0, 1'b0, fetch);
        v("outbox_decode", 8'h10, 1'b0, 1'b1, 1'b0, none);
        for (int k = 0; k < 2; k++) v("outbox_stall", 8'h10, 1'b0, 1'b1, 1'b0, none);
        v("outbox_exec",   8'h10, 1'b0, 1'b0, 1'b0, mk(3'b000, S_OUTWR, 2'b00, 1'b0, 1'b0));
        // Direct-operand opcodes.
        op4("add",      8'h45, 1'b0, mk(3'b000, S_RLD,           2'b10, 1'b0, 1'b0));
        op4("sub",      8'h53, 1'b0, mk(3'b001, S_RLD,           2'b10, 1'b0, 1'b0));
        op4("copyfrom", 8'h21, 1'b0, mk(3'b000, S_RLD,           2'b01, 1'b0, 1'b0));
        op4("copyto",   8'h31, 1'b0, mk(3'b000, S_MEMWR,         2'b00, 1'b0, 1'b0));
        op4("bumpdn",   8'h72, 1'b0, mk(3'b011, S_RLD | S_MEMWR, 2'b10, 1'b0, 1'b0));
        op4("jump",     8'h80, 1'b0, mk(3'b000, S_PCLD,          2'b00, 1'b0, 1'b0));
        op4("jumpz_f0", 8'h90, 1'b0, mk(3'b000, S_NONE,          2'b00, 1'b0, 1'b0));
        op4("jumpz_f1", 8'h90, 1'b1, mk(3'b000, S_PCLD,          2'b00, 1'b0, 1'b0));
        op4("jumpn_f1", 8'hA0, 1'b1, mk(3'b100, S_PCLD,          2'b00, 1'b0, 1'b0));
        op4("jumpn_f0", 8'hA0, 1'b0, mk(3'b100, S_NONE,          2'b00, 1'b0, 1'b0));
        // Indirect bit ignored for INBOX and JUMP.
        v("inbox_ind_fetch",  8'h08, 1'b0, 1'b0, 1'b0, fetch);
        v("inbox_ind_decode", 8'h08, 1'b0, 1'b0, 1'b0, none);
        v("inbox_ind_exec",   8'h08, 1'b0, 1'b0, 1'b0, mk(3'b000, S_RLD | S_INRD, 2'b00, 1'b0, 1'b0));
        op4("jump_ind", 8'h88, 1'b0, mk(3'b000, S_PCLD, 2'b00, 1'b0, 1'b0));
        // BUMPUP with the indirect bit set.
        v("bumpup_ind_fetch",  8'h68, 1'b0, 1'b0, 1'b0, fetch);
        v("bumpup_ind_decode", 8'h68, 1'b0, 1'b0, 1'b0, none);
        v("bumpup_ind_arg",    8'h05, 1'b0, 1'b0, 1'b0, mk(3'b000, S_ARG, 2'b00, 1'b0, 1'b0));
`ifdef INDIRECT_ADDR_EN
        v("bumpup_ind_indir",  8'h00, 1'b0, 1'b0, 1'b0, mk(3'b000, S_ARIND, 2'b00, 1'b0, 1'b0));
`endif
        v("bumpup_ind_exec",   8'h00, 1'b0, 1'b0, 1'b0, mk(3'b010, S_RLD | S_MEMWR, 2'b10, 1'b0, 1'b0));

        // Reset state.
        applyStimulus("reset_0", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, none);
        applyStimulus("reset_1", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, none);

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].name, 1'b0, vecs[n].instr, vecs[n].ie, vecs[n].of, vecs[n].fl, vecs[n].exp);
        end

        // Reset during an INBOX stall abandons it with no strobe in the reset cycle.
        applyStimulus("midstall_fetch",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, fetch);
        applyStimulus("midstall_decode", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, none);
        applyStimulus("midstall_stall",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, none);
        applyStimulus("midstall_rst",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, none);
        applyStimulus("midstall_resume", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fetch);
        applyStimulus("midstall_decode2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, none);
        applyStimulus("midstall_exec",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                      mk(3'b000, S_RLD | S_INRD, 2'b00, 1'b0, 1'b0));

        // Legal HALT: halted only, held.
        applyStimulus("halt_fetch",  1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, fetch);
        applyStimulus("halt_decode", 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, none);
        for (int k = 0; k < 3; k++)
            applyStimulus("halt_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, mk(3'b000, S_NONE, 2'b00, 1'b1, 1'b0));
        applyStimulus("halt_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, none);

        // Illegal opcode: halted and illegal for 10 cycles, then cleared by reset.
        applyStimulus("illegal_fetch",  1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, fetch);
        applyStimulus("illegal_decode", 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, none);
        for (int k = 0; k < 10; k++)
            applyStimulus("illegal_hold", 1'b0, 8'h45, 1'b0, 1'b0, 1'b1, mk(3'b000, S_NONE, 2'b00, 1'b1, 1'b1));
        applyStimulus("illegal_rst",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, none);
        applyStimulus("illegal_resume", 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, fetch);
        applyStimulus("illegal_decode2", 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, none);
        applyStimulus("illegal_exec",   1'b0, 8'h10, 1'b0, 1'b0, 1'b0,
                      mk(3'b000, S_OUTWR, 2'b00, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
